// File: rtl/bsg_fpu_pkg.sv
// Shared FPU definitions: bit positions of the one-hot class mask.
package bsg_fpu_pkg;

  localparam int unsigned cls_neg_inf_lp  = 0;
  localparam int unsigned cls_neg_norm_lp = 1;
  localparam int unsigned cls_neg_sub_lp  = 2;
  localparam int unsigned cls_neg_zero_lp = 3;
  localparam int unsigned cls_pos_zero_lp = 4;
  localparam int unsigned cls_pos_sub_lp  = 5;
  localparam int unsigned cls_pos_norm_lp = 6;
  localparam int unsigned cls_pos_inf_lp  = 7;
  localparam int unsigned cls_snan_lp     = 8;
  localparam int unsigned cls_qnan_lp     = 9;
  localparam int unsigned cls_width_lp    = 10;

  typedef logic [cls_width_lp-1:0] cls_mask_t;

endpackage

// File: rtl/bsg_fpu_classify.sv
// Combinational IEEE-style classifier: one-hot class mask for an e_p/m_p float.
module bsg_fpu_classify
  import bsg_fpu_pkg::*;
#(
  parameter int e_p = 5,
  parameter int m_p = 10,
  localparam int w_lp = e_p + m_p + 1
) (
  input  logic [w_lp-1:0] a_i,
  output logic [w_lp-1:0] class_o
);

  logic           sign;
  logic [e_p-1:0] exp_f;
  logic [m_p-1:0] man_f;
  logic           exp_max, exp_zero, man_zero;
  cls_mask_t      cls;

  assign sign     = a_i[w_lp-1];
  assign exp_f    = a_i[w_lp-2 -: e_p];
  assign man_f    = a_i[m_p-1:0];
  assign exp_max  = &exp_f;
  assign exp_zero = ~|exp_f;
  assign man_zero = ~|man_f;

  always_comb begin
    cls = '0;
    if (exp_max) begin
      if (man_zero) begin
        if (sign) cls[cls_neg_inf_lp] = 1'b1;
        else      cls[cls_pos_inf_lp] = 1'b1;
      end else if (man_f[m_p-1]) begin
        cls[cls_qnan_lp] = 1'b1;
      end else begin
        cls[cls_snan_lp] = 1'b1;
      end
    end else if (exp_zero) begin
      if (man_zero) begin
        if (sign) cls[cls_neg_zero_lp] = 1'b1;
        else      cls[cls_pos_zero_lp] = 1'b1;
      end else begin
        if (sign) cls[cls_neg_sub_lp] = 1'b1;
        else      cls[cls_pos_sub_lp] = 1'b1;
      end
    end else begin
      if (sign) cls[cls_neg_norm_lp] = 1'b1;
      else      cls[cls_pos_norm_lp] = 1'b1;
    end
  end

  // Bits above the ten defined classes stay zero.
  assign class_o = w_lp'(cls);

endmodule

// File: rtl/bsg_fpu_classify_arb.sv
// Round-robin arbiter over num_req_p operand requesters feeding one classifier
// and a single valid/yumi output register with a sticky signaling-NaN flag.
module bsg_fpu_classify_arb
  import bsg_fpu_pkg::*;
#(
  parameter int e_p       = 5,
  parameter int m_p       = 10,
  parameter int num_req_p = 4,
  localparam int w_lp     = e_p + m_p + 1,
  localparam int lg_lp    = $clog2(num_req_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_req_p-1:0]      v_i,
  input  logic [num_req_p*w_lp-1:0] a_i,
  output logic [num_req_p-1:0]      ready_and_o,
  output logic                      v_o,
  output logic [w_lp-1:0]           class_o,
  output logic [lg_lp-1:0]          tag_o,
  input  logic                      yumi_i,
  input  logic                      clear_i,
  output logic                      invalid_o
);

  logic [lg_lp-1:0] last_grant_r;
  logic [lg_lp-1:0] grant, cand;
  logic             grant_v, open, load;
  logic [w_lp-1:0]  ops [num_req_p];
  logic [w_lp-1:0]  op_sel, cls;

  for (genvar k = 0; k < num_req_p; k++) begin : g_ops
    assign ops[k] = a_i[k*w_lp +: w_lp];
  end

  assign open = ~v_o | yumi_i;

  // Scan starts one past the last winner so every active requester gets a turn.
  always_comb begin
    grant_v = 1'b0;
    grant   = '0;
    cand    = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      cand = lg_lp'((int'(last_grant_r) + i) % num_req_p);
      if (!grant_v && v_i[cand]) begin
        grant_v = 1'b1;
        grant   = cand;
      end
    end
  end

  always_comb begin
    ready_and_o = '0;
    if (!reset_i && open && grant_v) ready_and_o[grant] = 1'b1;
  end

  assign load   = open & grant_v;
  assign op_sel = ops[grant];

  bsg_fpu_classify #(.e_p(e_p), .m_p(m_p)) classify (
    .a_i    (op_sel),
    .class_o(cls)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o          <= 1'b0;
      class_o      <= '0;
      tag_o        <= '0;
      last_grant_r <= lg_lp'(num_req_p - 1);
      invalid_o    <= 1'b0;
    end else begin
      if (load) begin
        v_o          <= 1'b1;
        class_o      <= cls;
        tag_o        <= grant;
        last_grant_r <= grant;
      end else if (yumi_i) begin
        v_o <= 1'b0;
      end
      // A new sNaN outranks a simultaneous clear.
      if (load && cls[cls_snan_lp]) invalid_o <= 1'b1;
      else if (clear_i)              invalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bsg_fpu_classify_arb.sv
// Directed bench for bsg_fpu_classify_arb with a cycle-level reference model.
module tb_bsg_fpu_classify_arb;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [3:0]  v_i = '0;
  logic [15:0] a [4];
  logic [63:0] a_i;
  logic [3:0]  ready;
  logic        v_o;
  logic [15:0] class_o;
  logic [1:0]  tag_o;
  logic        yumi_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        invalid_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_v = 1'b0;
  logic [15:0] m_cls = '0;
  int          m_tag = 0;
  logic        m_inv = 1'b0;
  int          m_last = 3;

  assign a_i = {a[3], a[2], a[1], a[0]};

  always #5 clk = ~clk;

  bsg_fpu_classify_arb #(.e_p(5), .m_p(10), .num_req_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .a_i(a_i),
    .ready_and_o(ready), .v_o(v_o), .class_o(class_o), .tag_o(tag_o),
    .yumi_i(yumi_i), .clear_i(clear_i), .invalid_o(invalid_o)
  );

  // Half-precision class from magnitude ranges of the raw encoding.
  function automatic logic [15:0] mclass(input logic [15:0] x);
    logic [15:0] mag;
    logic neg;
    mag = {1'b0, x[14:0]};
    neg = x[15];
    if (mag == 16'h0000)      return neg ? 16'h0008 : 16'h0010;
    else if (mag < 16'h0400)  return neg ? 16'h0004 : 16'h0020;
    else if (mag < 16'h7C00)  return neg ? 16'h0002 : 16'h0040;
    else if (mag == 16'h7C00) return neg ? 16'h0001 : 16'h0080;
    else if (mag >= 16'h7E00) return 16'h0200;
    else                      return 16'h0100;
  endfunction

  function automatic logic [3:0] model_ready();
    if (m_v && !yumi_i) return 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (m_last + i) % 4;
      if (v_i[k]) return 4'b0001 << k;
    end
    return 4'b0000;
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_v = 1'b0; m_cls = '0; m_tag = 0; m_inv = 1'b0; m_last = 3;
    end else begin
      logic [3:0] r;
      logic snan;
      r = model_ready();
      snan = 1'b0;
      if (r != 4'b0000) begin
        for (int k = 0; k < 4; k++)
          if (r[k]) begin
            m_v = 1'b1; m_cls = mclass(a[k]); m_tag = k; m_last = k;
            snan = (m_cls == 16'h0100);
          end
      end else if (yumi_i) begin
        m_v = 1'b0;
      end
      if (snan) m_inv = 1'b1;
      else if (clear_i) m_inv = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_i) begin
      chk("model ready", 16'(ready), 16'(model_ready()));
      chk("model v_o", 16'(v_o), 16'(m_v));
      chk("model class", class_o, m_cls);
      chk("model tag", 16'(tag_o), 16'(m_tag));
      chk("model invalid", 16'(invalid_o), 16'(m_inv));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          exp_tag [5] = '{0, 1, 2, 3, 0};
  logic [15:0] exp_cls [5] = '{16'h0040, 16'h0008, 16'h0020, 16'h0200, 16'h0040};
  logic [15:0] pats [10] = '{16'h0000, 16'h8000, 16'h0001, 16'h8001, 16'h3C00,
                             16'hBC00, 16'h7C00, 16'hFC00, 16'h7C01, 16'h7E00};

  initial begin
    for (int k = 0; k < 4; k++) a[k] = 16'h0000;
    reset_i = 1'b1;
    v_i = 4'b1111;
    #3;
    chk("reset ready", 16'(ready), 16'h0000);
    chk("reset v_o", 16'(v_o), 16'h0000);
    chk("reset class", class_o, 16'h0000);
    chk("reset tag", 16'(tag_o), 16'h0000);
    chk("reset invalid", 16'(invalid_o), 16'h0000);

    // first grant right after reset release
    @(posedge clk); #1;
    reset_i = 1'b0;
    v_i = 4'b0001; a[0] = 16'hFC00; yumi_i = 1'b1;
    step();
    chk("neg inf v_o", 16'(v_o), 16'h0001);
    chk("neg inf class", class_o, 16'h0001);
    chk("neg inf tag", 16'(tag_o), 16'h0000);

    // all requesters active: strict rotation
    reset_i = 1'b1; #2; reset_i = 1'b0;
    v_i = 4'b1111; yumi_i = 1'b1;
    a[0] = 16'h3C00; a[1] = 16'h8000; a[2] = 16'h0001; a[3] = 16'h7E00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr tag", 16'(tag_o), 16'(exp_tag[i]));
      chk("rr class", class_o, exp_cls[i]);
    end

    // backpressure hold
    v_i = 4'b0010; yumi_i = 1'b0;
    #1;
    chk("hold ready", 16'(ready), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold v_o", 16'(v_o), 16'h0001);
      chk("hold tag", 16'(tag_o), 16'h0000);
      chk("hold class", class_o, 16'h0040);
      chk("hold ready", 16'(ready), 16'h0000);
    end
    yumi_i = 1'b1;
    #1;
    chk("yumi ready", 16'(ready), 16'h0002);
    step();
    chk("after hold tag", 16'(tag_o), 16'h0001);
    chk("after hold class", class_o, 16'h0008);

    // sticky invalid
    v_i = 4'b0100; a[2] = 16'h7C01; yumi_i = 1'b1;
    step();
    chk("snan class", class_o, 16'h0100);
    chk("snan tag", 16'(tag_o), 16'h0002);
    chk("snan invalid", 16'(invalid_o), 16'h0001);
    v_i = 4'b0000; clear_i = 1'b1;
    step();
    chk("clear invalid", 16'(invalid_o), 16'h0000);
    chk("drain v_o", 16'(v_o), 16'h0000);
    v_i = 4'b0100; yumi_i = 1'b0;
    step();
    chk("set beats clear", 16'(invalid_o), 16'h0001);
    clear_i = 1'b0; v_i = 4'b0000; yumi_i = 1'b1;
    step();

    // zeros and subnormals, single requester every cycle
    v_i = 4'b0001; a[0] = 16'h0000;
    step();
    chk("pos zero class", class_o, 16'h0010);
    a[0] = 16'h8001;
    step();
    chk("neg sub class", class_o, 16'h0004);
    chk("neg sub tag", 16'(tag_o), 16'h0000);
    v_i = 4'b0000;
    step();
    chk("empty v_o", 16'(v_o), 16'h0000);
    chk("empty class hold", class_o, 16'h0004);

    // async reset mid-stream
    v_i = 4'b1111;
    a[0] = 16'h7C01; a[1] = 16'h3C00; a[2] = 16'h3C00; a[3] = 16'h3C00;
    repeat (4) step();
    chk("pre reset tag", 16'(tag_o), 16'h0000);
    chk("pre reset invalid", 16'(invalid_o), 16'h0001);
    #1 reset_i = 1'b1;
    #1;
    chk("async v_o", 16'(v_o), 16'h0000);
    chk("async invalid", 16'(invalid_o), 16'h0000);
    chk("async ready", 16'(ready), 16'h0000);
    #1 reset_i = 1'b0;
    step();
    chk("post reset tag", 16'(tag_o), 16'h0000);
    chk("post reset v_o", 16'(v_o), 16'h0001);

    // mixed traffic against the model
    for (int n = 0; n < 60; n++) begin
      v_i = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) a[k] = pats[$urandom_range(0, 9)];
      yumi_i = 1'($urandom_range(0, 1));
      clear_i = ($urandom_range(0, 3) == 0);
      step();
    end
    v_i = 4'b0000; yumi_i = 1'b1; clear_i = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
